// File: rtl/serdes_packer.sv
// serdes_packer: bit-compacting gearbox for the serdes transmit path.
// Accepts 0..IN_W LSB-aligned bits per cycle into a gap-free bit queue and
// emits OUT_W-bit words LSB-first with a per-bit enable. Supports
// backpressure, explicit flush and a sticky overflow flag.
// Optional macro SERDES_PACKER_IDLE_FLUSH_EN: adds an idle counter that
// forces out a partial word after IDLE_CYCLES quiet edges.
module serdes_packer #(
    parameter int IN_W        = 2,
    parameter int OUT_W       = 2,
    parameter int BUF_W       = 6,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IN_W-1:0]            in_bits,
    input  logic [$clog2(IN_W+1)-1:0]  in_count,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [OUT_W-1:0]           serdes_out,
    output logic [OUT_W-1:0]           serdes_en,
    output logic                       overflow
);

    localparam int CW = $clog2(IN_W + 1);
    localparam int FW = $clog2(BUF_W + 1);

    localparam logic [CW-1:0] IN_MAX    = CW'(IN_W);
    localparam logic [FW-1:0] OUT_FILL  = FW'(OUT_W);
    localparam logic [FW-1:0] READY_MAX = FW'(BUF_W - IN_W);

    // The queue must hold a full input word on top of a partial output word.
    if (BUF_W < IN_W + OUT_W) begin : g_bad_buf_w
        $error("serdes_packer: BUF_W (%0d) must be >= IN_W + OUT_W (%0d)", BUF_W, IN_W + OUT_W);
    end
    if (IDLE_CYCLES < 0) begin : g_bad_idle
        $error("serdes_packer: IDLE_CYCLES must be non-negative");
    end

    logic [BUF_W-1:0] queue;
    logic [BUF_W-1:0] queue_rem;
    logic [BUF_W-1:0] queue_nxt;
    logic [BUF_W-1:0] in_ext;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_rem;
    logic [FW-1:0]    fill_nxt;
    logic [CW-1:0]    n_eff;
    logic [OUT_W-1:0] fill_mask;
    logic [OUT_W-1:0] out_nxt;
    logic [OUT_W-1:0] en_nxt;
    logic             accept;
    logic             do_full;
    logic             do_flush;
    logic             flush_req;

    // Ready depends on the fill register only, never on inputs.
    assign in_ready = (fill <= READY_MAX);
    assign accept   = in_valid & in_ready;

`ifdef SERDES_PACKER_IDLE_FLUSH_EN
    localparam int IW = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    logic [IW-1:0] idle_cnt;

    assign flush_req = flush | (idle_cnt == IDLE_MAX);

    // Idle counter: counts quiet edges while a partial word sits in the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (do_full || do_flush || (accept && (n_eff != '0))) begin
            idle_cnt <= '0;
        end else if ((fill != '0) && !do_full) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    assign flush_req = flush;
`endif

    // Emit decision on the pre-edge fill, then append accepted bits behind
    // whatever remains after removal.
    always_comb begin
        n_eff     = (in_count > IN_MAX) ? IN_MAX : in_count;
        do_full   = (fill >= OUT_FILL);
        do_flush  = !do_full && flush_req && (fill != '0);

        fill_mask = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            fill_mask[i] = (i < 32'(fill));
        end

        in_ext = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            in_ext[i] = in_bits[i] & (i < 32'(n_eff));
        end

        out_nxt   = '0;
        en_nxt    = '0;
        queue_rem = queue;
        fill_rem  = fill;
        if (do_full) begin
            out_nxt   = queue[OUT_W-1:0];
            en_nxt    = '1;
            queue_rem = queue >> OUT_W;
            fill_rem  = fill - OUT_FILL;
        end else if (do_flush) begin
            out_nxt   = queue[OUT_W-1:0] & fill_mask;
            en_nxt    = fill_mask;
            queue_rem = '0;
            fill_rem  = '0;
        end

        queue_nxt = queue_rem;
        fill_nxt  = fill_rem;
        if (accept) begin
            queue_nxt = queue_rem | (in_ext << fill_rem);
            fill_nxt  = fill_rem + FW'(n_eff);
        end
    end

    // Queue, output word and sticky overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            queue      <= '0;
            fill       <= '0;
            serdes_out <= '0;
            serdes_en  <= '0;
            overflow   <= 1'b0;
        end else begin
            queue      <= queue_nxt;
            fill       <= fill_nxt;
            serdes_out <= out_nxt;
            serdes_en  <= en_nxt;
            overflow   <= overflow | (in_valid & ~in_ready);
        end
    end

endmodule

// File: tb/tb_serdes_packer.sv
// Testbench for serdes_packer: two instances (2/2/6 and 4/2/8 widths),
// each checked against a bit-queue reference model.
// Honours SERDES_PACKER_IDLE_FLUSH_EN when defined for the whole build.
module tb_serdes_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic [1:0] bits0;
    logic [1:0] cnt0;
    logic       v0, f0, rdy0, ovf0;
    logic [1:0] out0, en0;

    logic [3:0] bits1;
    logic [2:0] cnt1;
    logic       v1, f1, rdy1, ovf1;
    logic [1:0] out1, en1;

    serdes_packer #(.IN_W(2), .OUT_W(2), .BUF_W(6), .IDLE_CYCLES(3)) u_p0 (
        .clk(clk), .reset(reset), .in_bits(bits0), .in_count(cnt0),
        .in_valid(v0), .in_ready(rdy0), .flush(f0),
        .serdes_out(out0), .serdes_en(en0), .overflow(ovf0)
    );

    serdes_packer #(.IN_W(4), .OUT_W(2), .BUF_W(8), .IDLE_CYCLES(3)) u_p1 (
        .clk(clk), .reset(reset), .in_bits(bits1), .in_count(cnt1),
        .in_valid(v1), .in_ready(rdy1), .flush(f1),
        .serdes_out(out1), .serdes_en(en1), .overflow(ovf1)
    );

    int    passed = 0;
    int    total  = 0;
    int    tick_err = 0;
    string tick_msg = "";

    bit         mq0[$];
    bit         mq1[$];
    bit         movf[2];
    logic [1:0] e_out[2];
    logic [1:0] e_en[2];
`ifdef SERDES_PACKER_IDLE_FLUSH_EN
    int         midle[2];
`endif

    task automatic note(input string s);
        tick_err++;
        if (tick_err == 1) tick_msg = s;
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        movf = '{1'b0, 1'b0};
`ifdef SERDES_PACKER_IDLE_FLUSH_EN
        midle = '{0, 0};
`endif
    endtask

    // Reference: a queue of bits, oldest at the front.
    task automatic model_one(input int d, input logic valid, input int bitsv,
                             input int cntv, input logic fl, input logic a_rdy);
        bit         q[$];
        int         iw, bw, sz, n;
        bit         rdy, fire, emitted;
        logic [1:0] eo, ee;
        if (d == 0) begin q = mq0; iw = 2; bw = 6; end
        else        begin q = mq1; iw = 4; bw = 8; end
        sz  = q.size();
        rdy = (sz + iw <= bw);
        if (rdy !== a_rdy) note($sformatf("dut%0d in_ready got %b expected %b", d, a_rdy, rdy));
        fire = fl;
`ifdef SERDES_PACKER_IDLE_FLUSH_EN
        if (midle[d] == 3) fire = 1'b1;
`endif
        eo = '0; ee = '0; emitted = 1'b0;
        if (sz >= 2) begin
            for (int i = 0; i < 2; i++) begin eo[i] = q.pop_front(); ee[i] = 1'b1; end
            emitted = 1'b1;
        end else if (fire && sz > 0) begin
            for (int i = 0; i < sz; i++) begin eo[i] = q.pop_front(); ee[i] = 1'b1; end
            emitted = 1'b1;
        end
        n = (cntv > iw) ? iw : cntv;
        if (valid && rdy)
            for (int i = 0; i < n; i++) q.push_back(bit'((bitsv >> i) & 1));
        if (valid && !rdy) movf[d] = 1'b1;
`ifdef SERDES_PACKER_IDLE_FLUSH_EN
        if (emitted || (valid && rdy && n > 0)) midle[d] = 0;
        else if (sz > 0 && sz < 2) midle[d]++;
`endif
        if (d == 0) mq0 = q; else mq1 = q;
        e_out[d] = eo;
        e_en[d]  = ee;
    endtask

    // One clock: predict, advance, then record any disagreement.
    task automatic tick();
        model_one(0, v0, int'(bits0), int'(cnt0), f0, rdy0);
        model_one(1, v1, int'(bits1), int'(cnt1), f1, rdy1);
        @(posedge clk);
        #1;
        if (out0 !== e_out[0] || en0 !== e_en[0] || ovf0 !== movf[0])
            note($sformatf("dut0 out/en/ovf got %b/%b/%b expected %b/%b/%b",
                           out0, en0, ovf0, e_out[0], e_en[0], movf[0]));
        if (out1 !== e_out[1] || en1 !== e_en[1] || ovf1 !== movf[1])
            note($sformatf("dut1 out/en/ovf got %b/%b/%b expected %b/%b/%b",
                           out1, en1, ovf1, e_out[1], e_en[1], movf[1]));
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; f0 = 1'b0; cnt0 = '0; bits0 = '0;
        v1 = 1'b0; f1 = 1'b0; cnt1 = '0; bits1 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out0, en0, ovf0, rdy0, out1, en1, ovf1, rdy1} !== 12'b0000_0_1_0000_0_1)
            $display("FAIL reset_init: got %b expected %b",
                     {out0, en0, ovf0, rdy0, out1, en1, ovf1, rdy1}, 12'b0000_0_1_0000_0_1);
        else passed++;
        reset = 1'b0;

        // Fill dut0 to 3 bits of ones, dut1 to 6 ones, then reset mid-cycle.
        v0 = 1'b1; cnt0 = 2'd1; bits0 = 2'b11;
        v1 = 1'b1; cnt1 = 3'd4; bits1 = 4'hF;
        tick();
        cnt0 = 2'd2;
        tick();
        idle_inputs();
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({out0, en0, ovf0, rdy0, out1, en1, ovf1, rdy1} !== 12'b0000_0_1_0000_0_1)
            $display("FAIL reset_async: got %b expected %b",
                     {out0, en0, ovf0, rdy0, out1, en1, ovf1, rdy1}, 12'b0000_0_1_0000_0_1);
        else passed++;
        model_reset();
        #1;
        reset = 1'b0;

        v0 = 1'b1; cnt0 = 2'd2; bits0 = 2'b00;
        tick();
        idle_inputs();
        tick();
        total++;
        if ({out0, en0} !== 4'b0011)
            $display("FAIL reset_no_stale: got %b expected %b", {out0, en0}, 4'b0011);
        else passed++;
        total++;
        if (tick_err !== 0) $display("FAIL reset_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    task automatic test_compaction();
        logic [3:0] obs[5];
        v0 = 1'b1; cnt0 = 2'd1; bits0 = 2'b01; tick(); obs[0] = {out0, en0};
        cnt0 = 2'd1; bits0 = 2'b00;           tick(); obs[1] = {out0, en0};
        cnt0 = 2'd2; bits0 = 2'b11;           tick(); obs[2] = {out0, en0};
        idle_inputs();
        tick(); obs[3] = {out0, en0};
        tick(); obs[4] = {out0, en0};
        total++;
        if (obs[2] !== 4'b0111) $display("FAIL compact_word1: got %b expected %b", obs[2], 4'b0111);
        else passed++;
        total++;
        if (obs[3] !== 4'b1111) $display("FAIL compact_word2: got %b expected %b", obs[3], 4'b1111);
        else passed++;
        total++;
        if (obs[4] !== 4'b0000) $display("FAIL compact_idle: got %b expected %b", obs[4], 4'b0000);
        else passed++;
        total++;
        if (tick_err !== 0) $display("FAIL compact_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    task automatic test_gearbox();
        int acc = 0;
        int full = 0;
        cnt1 = 3'd4;
        for (int i = 0; i < 40; i++) begin
            v1    = rdy1;
            bits1 = 4'($urandom);
            if (v1) acc++;
            tick();
            if (i > 0 && en1 === 2'b11) full++;
        end
        idle_inputs();
        repeat (5) tick();
        total++;
        if (acc < 20 || acc > 21) $display("FAIL gear_accepts: got %0d expected 20..21", acc);
        else passed++;
        total++;
        if (full !== 39) $display("FAIL gear_full_words: got %0d expected %0d", full, 39);
        else passed++;
        total++;
        if (ovf1 !== 1'b0) $display("FAIL gear_overflow: got %b expected %b", ovf1, 1'b0);
        else passed++;
        total++;
        if (tick_err !== 0) $display("FAIL gear_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    task automatic test_flush();
        v0 = 1'b1; cnt0 = 2'd1; bits0 = 2'b01; tick();
        idle_inputs(); f0 = 1'b1; tick();
        total++;
        if ({out0, en0} !== 4'b0101) $display("FAIL flush_partial: got %b expected %b", {out0, en0}, 4'b0101);
        else passed++;
        tick();
        total++;
        if ({out0, en0} !== 4'b0000) $display("FAIL flush_empty: got %b expected %b", {out0, en0}, 4'b0000);
        else passed++;
        f0 = 1'b0; v0 = 1'b1; cnt0 = 2'd1; bits0 = 2'b01; tick();
        cnt0 = 2'd2; bits0 = 2'b10; tick();
        idle_inputs(); f0 = 1'b1; tick();
        total++;
        if ({out0, en0} !== 4'b0111) $display("FAIL flush_full_first: got %b expected %b", {out0, en0}, 4'b0111);
        else passed++;
        tick();
        total++;
        if ({out0, en0} !== 4'b0101) $display("FAIL flush_remainder: got %b expected %b", {out0, en0}, 4'b0101);
        else passed++;
        f0 = 1'b0;
        total++;
        if (tick_err !== 0) $display("FAIL flush_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    task automatic test_overflow();
        int blocked = 0;
        v1 = 1'b1; cnt1 = 3'd4;
        for (int i = 0; i < 8; i++) begin
            bits1 = 4'($urandom);
            if (!rdy1) blocked++;
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        total++;
        if (blocked < 3) $display("FAIL ovf_blocked: got %0d expected >=3", blocked);
        else passed++;
        total++;
        if (ovf1 !== 1'b1) $display("FAIL ovf_sticky: got %b expected %b", ovf1, 1'b1);
        else passed++;
        total++;
        if (ovf0 !== 1'b0) $display("FAIL ovf_other: got %b expected %b", ovf0, 1'b0);
        else passed++;
        total++;
        if (tick_err !== 0) $display("FAIL ovf_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    task automatic test_idle();
        int bad = 0;
        logic [1:0] want;
        v0 = 1'b1; cnt0 = 2'd1; bits0 = 2'b01; tick();
        idle_inputs();
        for (int i = 1; i <= 6; i++) begin
            tick();
`ifdef SERDES_PACKER_IDLE_FLUSH_EN
            want = (i == 4) ? 2'b01 : 2'b00;
`else
            want = 2'b00;
`endif
            if (en0 !== want) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL idle_timing: got %0d wrong edges expected 0", bad);
        else passed++;
        f0 = 1'b1; tick(); f0 = 1'b0;
        total++;
        if (tick_err !== 0) $display("FAIL idle_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(3) != 0); cnt0 = 2'($urandom); bits0 = 2'($urandom);
            f0 = ($urandom_range(7) == 0);
            v1 = ($urandom_range(3) != 0); cnt1 = 3'($urandom); bits1 = 4'($urandom);
            f1 = ($urandom_range(7) == 0);
            tick();
        end
        idle_inputs();
        repeat (8) tick();
        total++;
        if (tick_err !== 0) $display("FAIL random_model: got %0d mismatches expected 0; %s", tick_err, tick_msg);
        else passed++;
        tick_err = 0;
    endtask

    initial begin
        test_reset();
        test_compaction();
        test_gearbox();
        test_flush();
        test_overflow();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
